fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage directly downstream of the 10-bit program counter register. It consumes the registered PC, drives the synchronous instruction memory, and delivers PC/instruction pairs to decode over a valid/ready handshake. It also computes the next-PC value that feeds back into the PC register's input, closing the fetch loop. Redirect from execute, a halt opcode, and decode back-pressure are handled here through a 1-entry skid buffer.

Parameters:
PC_W, 10, program counter width (word address)
INSTR_W, 32, instruction width
RESET_PC, 0, pc_next value driven while reset is high
HALT_OPC, 6'b111111, opcode in instr[31:26] that halts fetch

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
pc_cur  input  PC_W  current PC from the PC register output
pc_next  output  PC_W  next PC, drives the PC register input (combinational)
imem_addr  output  PC_W  instruction memory read address (combinational, = pc_cur)
imem_rdata  input  INSTR_W  instruction memory data, valid one cycle after address
redirect_valid  input  1  taken branch/jump from execute
redirect_pc  input  PC_W  redirect target
out_valid  output  1  instruction available to decode
out_ready  input  1  decode accepts this cycle
out_pc  output  PC_W  PC of delivered instruction
out_instr  output  INSTR_W  delivered instruction
halted  output  1  fetch stopped by HALT_OPC
fetch_count  output  16  count of accepted instructions, wraps at 2^16

Behaviour:
- Reset value of every output and state bit (synchronous, active-high): f1_valid=0, skid_valid=0, halted=0, fetch_count=0, out_valid=0. pc_next=RESET_PC while reset is high.
- State: f1_valid/f1_pc (request issued last cycle; imem_rdata belongs to f1_pc this cycle) and skid_valid/skid_pc/skid_instr.
- Output mux: out_valid = !redirect_valid && (skid_valid || f1_valid). The skid has priority: out_pc/out_instr come from skid_pc/skid_instr when skid_valid, otherwise from f1_pc/imem_rdata.
- stall = out_valid && !out_ready.
- issue = !reset && !halted && !redirect_valid && !stall.
- pc_next priority:
  - reset → RESET_PC
  - redirect_valid → redirect_pc
  - issue → pc_cur+1, modulo 2^PC_W (pc_cur=10'h3FF gives 10'h000)
  - otherwise → pc_cur (hold)
- On each clock: f1_valid <= issue; f1_pc <= pc_cur.
- Skid capture: if f1_valid && !skid_valid && !out_ready && !redirect_valid, then skid <= {f1_pc, imem_rdata} and skid_valid <= 1.
- Skid drain: skid_valid clears when skid_valid && out_ready.
- Invariant: f1_valid and skid_valid are never both 1. No issue occurs in a capture cycle. Verification asserts this.
- Latency: an unstalled instruction appears on out_* exactly 1 cycle after its PC is on pc_cur. Sustained throughput is 1 per cycle with out_ready held high.
- Handshake: while out_valid=1 and out_ready=0, out_pc and out_instr hold stable. A transfer occurs when out_valid && out_ready.
- Redirect (highest priority after reset):
  - f1_valid and skid_valid clear next cycle.
  - out_valid is forced 0 in the redirect cycle, and no transfer occurs.
  - halted clears.
  - The first redirected instruction appears 2 cycles after redirect asserts.
- Halt: when a transfer occurs with out_instr[31:26]==HALT_OPC, halted <= 1. The HALT instruction itself is delivered. After that, no further issue and pc_next=pc_cur. halted clears only on reset or redirect_valid. An instruction already in flight (f1) is still delivered.
- fetch_count increments by 1 on every transfer. It wraps 16'hFFFF → 0.
- Reset mid-operation: all in-flight and skid contents are discarded next edge, with no delivery in the reset cycle.

Test Plan:
- Reset release, out_ready=1, imem holding word = 0x100+addr: out_valid first rises 1 cycle after reset falls with out_pc=0, out_instr=0x100. Then pc 1, 2, 3 on consecutive cycles; fetch_count=4 after 4 transfers.
- Drop out_ready for 3 cycles while pc=5 is displayed: out_pc=5 and out_instr held stable, pc_next=pc_cur, skid_valid=1. On re-assert, 5 is delivered once, then 6 follows the next cycle with no loss or duplicate.
- redirect_valid with redirect_pc=0x200 while f1 holds pc 7: out_valid=0 that cycle and pc 7 is never delivered. pc_next=0x200, and out_pc=0x200 appears 2 cycles later.
- Word at address 4 = HALT_OPC<<26: after its transfer, halted=1, pc_next holds, and out_valid=0 after the in-flight word drains. Then redirect to 0: halted=0 and fetch resumes from 0.
- Redirect to 0x3FE with free-running fetch: delivered sequence 0x3FE, 0x3FF, 0x000.
- Assert reset for 1 cycle while the skid is full: next cycle out_valid=0, fetch_count=0, halted=0, with no delivery of the skid contents.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the synchronous instruction memory from the registered PC,
// computes the next PC, and hands PC/instruction pairs to decode through a 1-entry skid buffer.
module fetch_stage #(
    parameter int              PC_W     = 10,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [5:0]      HALT_OPC = 6'b111111
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc_cur,
    output logic [PC_W-1:0]    pc_next,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

    logic               r_vld_p1;
    logic [PC_W-1:0]    r_pc_p1;
    logic               r_skid_vld;
    logic [PC_W-1:0]    r_skid_pc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic               r_halted;
    logic [15:0]        r_fetch_count;

    logic w_stall;
    logic w_issue;
    logic w_xfer;
    logic w_capture;
    logic w_is_halt;

    // p0: request side, address straight from the PC register
    assign imem_addr = pc_cur;

    // Reset also masks delivery so nothing in flight is handed over during the reset cycle
    assign out_valid = !reset && !redirect_valid && (r_skid_vld || r_vld_p1);
    assign out_pc    = r_skid_vld ? r_skid_pc    : r_pc_p1;
    assign out_instr = r_skid_vld ? r_skid_instr : imem_rdata;

    assign w_stall   = out_valid && !out_ready;
    assign w_issue   = !reset && !r_halted && !redirect_valid && !w_stall;
    assign w_xfer    = out_valid && out_ready;
    assign w_capture = r_vld_p1 && !r_skid_vld && !out_ready && !redirect_valid;
    assign w_is_halt = (out_instr[INSTR_W-1 -: 6] == HALT_OPC);

    always_comb begin
        pc_next = pc_cur;
        if (reset)
            pc_next = RESET_PC;
        else if (redirect_valid)
            pc_next = redirect_pc;
        else if (w_issue)
            pc_next = pc_inc(pc_cur);
    end

    // p1: memory data returns; park it in the skid when decode is not ready
    always_ff @(posedge clk) begin
        r_pc_p1 <= pc_cur;
        if (w_capture) begin
            r_skid_pc    <= r_pc_p1;
            r_skid_instr <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1      <= 1'b0;
            r_skid_vld    <= 1'b0;
            r_halted      <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_vld_p1 <= w_issue;
            if (redirect_valid) begin
                r_skid_vld <= 1'b0;
                r_halted   <= 1'b0;
            end else begin
                if (w_capture)
                    r_skid_vld <= 1'b1;
                else if (r_skid_vld && out_ready)
                    r_skid_vld <= 1'b0;
                if (w_xfer && w_is_halt)
                    r_halted <= 1'b1;
            end
            if (w_xfer)
                r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign halted      = r_halted;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pc_cur;
    logic [9:0]  pc_next;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_pc;
    logic [31:0] out_instr;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] mem [1024];

    int n_chk  = 0;
    int n_pass = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_next(pc_next),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Environment: the PC register and the synchronous instruction memory
    always @(posedge clk) begin
        pc_cur     <= pc_next;
        imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    endtask

    // Reference model: a queue of fetched-but-undelivered PCs, the expected PC register,
    // the halt flag and the delivery count.
    logic [9:0]  m_q[$];
    logic [9:0]  m_pc;
    logic        m_halted;
    logic [15:0] m_count;
    bit          m_known = 1'b0;
    logic        e_ov, e_stall, e_issue, e_xfer;
    logic [9:0]  e_pn;
    logic [31:0] e_instr;

    always @(negedge clk) begin
        e_ov    = !reset && !redirect_valid && (m_q.size() != 0);
        e_instr = (m_q.size() != 0) ? mem[m_q[0]] : 32'h0;
        e_stall = e_ov && !out_ready;
        e_issue = !reset && !m_halted && !redirect_valid && !e_stall;
        e_xfer  = e_ov && out_ready;
        if (reset)               e_pn = 10'h000;
        else if (redirect_valid) e_pn = redirect_pc;
        else if (e_issue)        e_pn = m_pc + 10'd1;
        else                     e_pn = m_pc;

        if (m_known) begin
            chk("out_valid", 32'(out_valid), 32'(e_ov));
            if (e_ov) begin
                chk("out_pc", 32'(out_pc), 32'(m_q[0]));
                chk("out_instr", out_instr, e_instr);
            end
            chk("pc_next", 32'(pc_next), 32'(e_pn));
            chk("imem_addr", 32'(imem_addr), 32'(m_pc));
            chk("halted", 32'(halted), 32'(m_halted));
            chk("fetch_count", 32'(fetch_count), 32'(m_count));
            chk("f1_skid_exclusive", 32'(dut.r_vld_p1 && dut.r_skid_vld), 32'd0);
        end

        if (reset) begin
            m_q.delete();
            m_halted = 1'b0;
            m_count  = 16'd0;
            m_known  = 1'b1;
        end else if (redirect_valid) begin
            m_q.delete();
            m_halted = 1'b0;
        end else begin
            if (e_xfer) begin
                void'(m_q.pop_front());
                m_count = m_count + 16'd1;
                if (e_instr[31:26] == 6'b111111)
                    m_halted = 1'b1;
            end
            if (e_issue)
                m_q.push_back(m_pc);
        end
        m_pc = e_pn;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + 32'(i);
        reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 10'h000;
        step(); step(); step();

        // Reset release and streaming
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_pc", 32'(out_pc), 32'h000);
        chk("first_instr", out_instr, 32'h100);
        step(); step(); step(); step();
        @(negedge clk);
        chk("count_after_4", 32'(fetch_count), 32'd4);
        chk("pc4_shown", 32'(out_pc), 32'h004);

        // Back-pressure on pc 5 for three cycles
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall_pc", 32'(out_pc), 32'h005);
        chk("stall_pc_next_hold", 32'(pc_next), 32'h006);
        step();
        @(negedge clk);
        chk("skid_full", 32'(dut.r_skid_vld), 32'd1);
        chk("skid_pc", 32'(out_pc), 32'h005);
        chk("skid_instr", out_instr, 32'h105);
        step();
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_pc5", 32'(out_pc), 32'h005);
        step();
        @(negedge clk);
        chk("after_drain_pc6", 32'(out_pc), 32'h006);
        chk("count_after_6", 32'(fetch_count), 32'd6);

        // Redirect while pc 7 is in f1
        step();
        redirect_valid = 1'b1; redirect_pc = 10'h200;
        @(negedge clk);
        chk("redirect_valid_low", 32'(out_valid), 32'd0);
        chk("redirect_pc_next", 32'(pc_next), 32'h200);
        step();
        redirect_valid = 1'b0;
        step();
        @(negedge clk);
        chk("redirect_target_pc", 32'(out_pc), 32'h200);
        chk("redirect_target_instr", out_instr, 32'h300);
        chk("count_skips_7", 32'(fetch_count), 32'd7);

        // Halt at word 4
        step();
        mem[4] = 32'hFC00_0000;
        redirect_valid = 1'b1; redirect_pc = 10'h000;
        step();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            @(negedge clk);
            if (out_valid && out_pc == 10'h004) found = 1'b1;
        end
        chk("halt_word_seen", 32'(found), 32'd1);
        step();
        @(negedge clk);
        chk("halted_set", 32'(halted), 32'd1);
        chk("inflight_pc5", 32'(out_pc), 32'h005);
        chk("halt_pc_next_hold", 32'(pc_next), 32'h006);
        step();
        @(negedge clk);
        chk("halt_drained", 32'(out_valid), 32'd0);
        chk("halt_pc_next_hold2", 32'(pc_next), 32'h006);
        step();
        redirect_valid = 1'b1; redirect_pc = 10'h000;
        mem[4] = 32'h104;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("halted_cleared", 32'(halted), 32'd0);
        step();
        @(negedge clk);
        chk("resume_pc0", 32'(out_pc), 32'h000);
        chk("resume_valid", 32'(out_valid), 32'd1);

        // PC wrap
        step();
        redirect_valid = 1'b1; redirect_pc = 10'h3FE;
        step();
        redirect_valid = 1'b0;
        step();
        @(negedge clk);
        chk("wrap_3fe", 32'(out_pc), 32'h3FE);
        chk("wrap_pc_next", 32'(pc_next), 32'h000);
        step();
        @(negedge clk);
        chk("wrap_3ff", 32'(out_pc), 32'h3FF);
        chk("wrap_3ff_instr", out_instr, 32'h4FF);
        step();
        @(negedge clk);
        chk("wrap_000", 32'(out_pc), 32'h000);
        chk("wrap_000_instr", out_instr, 32'h100);

        // Reset while the skid is full
        step();
        out_ready = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("reset_cycle_skid_full", 32'(dut.r_skid_vld), 32'd1);
        chk("reset_cycle_no_valid", 32'(out_valid), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_valid", 32'(out_valid), 32'd0);
        chk("post_reset_count", 32'(fetch_count), 32'd0);
        chk("post_reset_halted", 32'(halted), 32'd0);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_reset_pc0", 32'(out_pc), 32'h000);

        // Mixed back-pressure with an occasional redirect, checked by the model
        for (int i = 0; i < 60; i++) begin
            step();
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = (i == 25);
            redirect_pc    = 10'h3F0;
        end
        step();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        step(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
